// File: rtl/outerprodrc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | outerprodrc_seq: sequenced outer-product unary GEMM engine (temporal rows, |
// | bit-reversed rate columns, signed accumulation). Option: OUTERPRODRC_SAT_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module outerprodrc_seq #(
  parameter int HIDDEN      = 4,
  parameter int ROWNUM      = 4,
  parameter int COLNUM      = 4,
  parameter int BITWIDTH    = 8,
  parameter int OUTBITWIDTH = 16
) (
  input  logic                                 iClk,
  input  logic                                 iRstN,
  input  logic                                 iEn,
  input  logic                                 iClr,
  input  logic                                 iStart,
  input  logic                                 iAccum,
  input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]    iData0,
  input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]    iData1,
  output logic                                 oBusy,
  output logic                                 oDone,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData
);

  localparam int M = BITWIDTH - 1;
  localparam logic [M-1:0] T_LAST = '1;
`ifdef OUTERPRODRC_SAT_EN
  // Extra headroom so the unclamped sum never wraps before the clamp.
  localparam int SW = OUTBITWIDTH + $clog2(HIDDEN + 1) + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUTBITWIDTH+1){1'b0}}, {(OUTBITWIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUTBITWIDTH+1){1'b1}}, {(OUTBITWIDTH-1){1'b0}}};
`else
  localparam int SW = OUTBITWIDTH;
`endif
  localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [M-1:0]                      r_t;
  logic [M-1:0]                      w_trev;
  logic [HIDDEN*ROWNUM*BITWIDTH-1:0] r_d0;
  logic [HIDDEN*COLNUM*BITWIDTH-1:0] r_d1;
  logic                              w_start;
  logic                              w_step;
  logic                              w_last;

  assign w_start = iStart && (r_state != S_RUN);
  assign w_step  = (r_state == S_RUN) && iEn;
  assign w_last  = w_step && (r_t == T_LAST);
  assign oBusy   = (r_state == S_RUN);
  assign oDone   = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_start ? S_RUN : S_IDLE;
      S_RUN:          if (w_last) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
    if (iClr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_t  <= '0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else if (iClr) begin
      r_t <= '0;
    end else if (w_start) begin
      r_t  <= '0;
      r_d0 <= iData0;
      r_d1 <= iData1;
    end else if (w_step) begin
      r_t <= r_t + 1'b1;
    end
  end

  always_comb begin
    w_trev = '0;
    for (int b = 0; b < M; b++) w_trev[b] = r_t[M-1-b];
  end

  for (genvar i = 0; i < ROWNUM; i++) begin : g_row
    for (genvar j = 0; j < COLNUM; j++) begin : g_col
      logic [OUTBITWIDTH-1:0] r_acc;
      logic [OUTBITWIDTH-1:0] r_out;
      logic [OUTBITWIDTH-1:0] w_nxt;
      logic signed [SW-1:0]   w_inc;
`ifdef OUTERPRODRC_SAT_EN
      logic signed [SW-1:0]   w_sum;
`endif

      always_comb begin
        w_inc = '0;
        for (int k = 0; k < HIDDEN; k++) begin
          if ((r_d0[(k*ROWNUM+i)*BITWIDTH +: M] > r_t) &&
              (r_d1[(k*COLNUM+j)*BITWIDTH +: M] > w_trev)) begin
            if (r_d0[(k*ROWNUM+i)*BITWIDTH+M] ^ r_d1[(k*COLNUM+j)*BITWIDTH+M])
              w_inc = w_inc - ONE;
            else
              w_inc = w_inc + ONE;
          end
        end
`ifdef OUTERPRODRC_SAT_EN
        w_sum = {{(SW-OUTBITWIDTH){r_acc[OUTBITWIDTH-1]}}, r_acc} + w_inc;
        if (w_sum > SAT_MAX)      w_nxt = SAT_MAX[OUTBITWIDTH-1:0];
        else if (w_sum < SAT_MIN) w_nxt = SAT_MIN[OUTBITWIDTH-1:0];
        else                      w_nxt = w_sum[OUTBITWIDTH-1:0];
`else
        w_nxt = r_acc + w_inc;
`endif
      end

      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          r_acc <= '0;
          r_out <= '0;
        end else if (iClr) begin
          r_acc <= '0;
          r_out <= '0;
        end else if (w_start) begin
          if (!iAccum) r_acc <= '0;
        end else if (w_step) begin
          r_acc <= w_nxt;
          if (w_last) r_out <= w_nxt;
        end
      end

      assign oData[(i*COLNUM+j)*OUTBITWIDTH +: OUTBITWIDTH] = r_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_outerprodrc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_outerprodrc_seq: scoreboard bench for outerprodrc_seq (2x2x2, 4-bit op, |
// | 4-bit accumulators). Revision: 1.0                                         |
// +----------------------------------------------------------------------------+
module tb_outerprodrc_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        accum = 1'b0;
  logic [15:0] d0 = '0;
  logic [15:0] d1 = '0;
  logic        busy;
  logic        done;
  logic [15:0] odata;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Operand/result nibbles: element index 0 in the low nibble.
  localparam logic [15:0] A_D0  = 16'h2C47;
  localparam logic [15:0] A_D1  = 16'hB447;
  localparam logic [15:0] A_EXP = 16'h1565;
  localparam logic [15:0] E_D0  = 16'h00C4;
  localparam logic [15:0] E_D1  = 16'h0004;
  localparam logic [15:0] E_EXP = 16'h0E02;
  localparam logic [15:0] D_D   = 16'h0007;
  localparam logic [15:0] B_D0  = 16'h8707;
  localparam logic [15:0] B_D1  = 16'hF7F7;
`ifdef OUTERPRODRC_SAT_EN
  localparam logic [15:0] D2_EXP = 16'h0007;
  localparam logic [15:0] B_EXP  = 16'h0087;
`else
  localparam logic [15:0] D2_EXP = 16'h000E;
  localparam logic [15:0] B_EXP  = 16'h002E;
`endif

  outerprodrc_seq #(
    .HIDDEN(2), .ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .OUTBITWIDTH(4)
  ) dut (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iStart(start),
    .iAccum(accum), .iData0(d0), .iData1(d1),
    .oBusy(busy), .oDone(done), .oData(odata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", odata, e.data);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic run_pass(input logic [15:0] a, input logic [15:0] b, input logic acc,
                          input logic [15:0] exp, input int stall, input bit expect_res);
    @(negedge clk);
    d0 = a; d1 = b; accum = acc; start = 1'b1;
    if (expect_res) sb_q.push_back('{data: exp, cyc: cyc + 9 + stall});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    if (stall > 0) begin
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (stall) @(negedge clk);
      en = 1'b1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", sb_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", odata, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(A_D0, A_D1, 1'b0, A_EXP, 0, 1'b1);
    drain();
    run_pass(E_D0, E_D1, 1'b0, E_EXP, 0, 1'b1);
    drain();
    run_pass(A_D0, A_D1, 1'b0, A_EXP, 3, 1'b1);
    drain();

    // Back-to-back: restart with accumulate in the oDone cycle.
    run_pass(D_D, D_D, 1'b0, D_D, 0, 1'b1);
    begin
      int n;
      for (n = 0; n < 20 && !done; n++) @(negedge clk);
      chk("b2b_done_seen", done, 1'b1);
      start = 1'b1; accum = 1'b1;
      sb_q.push_back('{data: D2_EXP, cyc: cyc + 9});
      @(negedge clk);
      start = 1'b0; accum = 1'b0;
      chk("b2b_busy", busy, 1'b1);
    end
    drain();

    run_pass(B_D0, B_D1, 1'b0, B_EXP, 0, 1'b1);
    drain();

    run_pass(A_D0, A_D1, 1'b0, A_EXP, 0, 1'b0);
    @(negedge clk);
    chk("pre_clr_busy", busy, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_data", odata, 16'h0000);
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", busy, 1'b0);
    repeat (14) @(negedge clk);

    run_pass(A_D0, A_D1, 1'b0, A_EXP, 0, 1'b1);
    repeat (2) @(negedge clk);
    d0 = E_D0; d1 = E_D1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    run_pass(E_D0, E_D1, 1'b0, E_EXP, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", odata, 16'h0000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);

    chk("final_queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
